char_to_time_parser: RTL and testbench

Sequential ASCII-to-BCD parser for the digital clock's time-setting path. It consumes a byte stream of ASCII characters, one qualified byte per cycle, and recognises the frame "HH:MM:SS" followed by a terminator. It validates the frame and, on success, publishes six BCD digits to the clock counters with a one-cycle load strobe. Malformed or out-of-range frames raise a one-cycle error strobe and leave the published time unchanged.

---
 rtl/clock_pkg.sv | 46 ++++
 rtl/char_to_num_decoder.sv | 13 +
 rtl/char_to_time_parser.sv | 124 ++++++++++++
 tb/tb_char_to_time_parser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the clock's ASCII time-setting path.
// Holds ASCII bounds, parser position encodings, error codes and the BCD range check.
package clock_pkg;

  localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_HI = 8'h39;
  localparam logic [7:0] ASCII_COLON    = 8'h3A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;

  localparam logic [3:0] POS_H_T  = 4'd0;
  localparam logic [3:0] POS_H_O  = 4'd1;
  localparam logic [3:0] POS_SEP1 = 4'd2;
  localparam logic [3:0] POS_M_T  = 4'd3;
  localparam logic [3:0] POS_M_O  = 4'd4;
  localparam logic [3:0] POS_SEP2 = 4'd5;
  localparam logic [3:0] POS_S_T  = 4'd6;
  localparam logic [3:0] POS_S_O  = 4'd7;
  localparam logic [3:0] POS_TERM = 4'd8;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_FORMAT = 2'b01;
  localparam logic [1:0] ERR_RANGE  = 2'b10;

  // Digit 5 is hour tens, digit 0 is seconds ones.
  typedef logic [5:0][3:0] bcd_time_t;

  function automatic logic [2:0] digit_idx(input logic [3:0] pos);
    logic [2:0] idx;
    case (pos)
      POS_H_T: idx = 3'd5;
      POS_H_O: idx = 3'd4;
      POS_M_T: idx = 3'd3;
      POS_M_O: idx = 3'd2;
      POS_S_T: idx = 3'd1;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic time_in_range(input bcd_time_t t);
    logic hours_ok;
    hours_ok = (t[5] < 4'd2) || ((t[5] == 4'd2) && (t[4] <= 4'd3));
    return hours_ok && (t[3] <= 4'd5) && (t[1] <= 4'd5);
  endfunction

endpackage

// File: rtl/char_to_num_decoder.sv
// Combinational ASCII digit decoder: flags '0'..'9' and returns its numeric value.
module char_to_num_decoder
  import clock_pkg::*;
(
  input  logic [7:0] char_data,
  output logic       is_digit,
  output logic [3:0] value
);

  assign is_digit = (char_data >= ASCII_DIGIT_LO) && (char_data <= ASCII_DIGIT_HI);
  assign value    = char_data[3:0];

endmodule

// File: rtl/char_to_time_parser.sv
// Parses "HH:MM:SS"+terminator into six registered BCD digits with load/error strobes.
// Range checking of the received time is enabled by defining PARSER_RANGE_CHECK_EN.
module char_to_time_parser
  import clock_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = ASCII_CR,
  parameter logic [7:0] SEP_CHAR  = ASCII_COLON
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic [3:0] hour_t,
  output logic [3:0] hour_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       time_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  logic       is_digit;
  logic [3:0] digit_val;
  logic       range_ok;

  logic [3:0] pos_q, pos_d;
  bcd_time_t  stg_q, stg_d;
  bcd_time_t  out_q, out_d;
  logic       tv_q, tv_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;

  char_to_num_decoder u_dec (
    .char_data (char_data),
    .is_digit  (is_digit),
    .value     (digit_val)
  );

`ifdef PARSER_RANGE_CHECK_EN
  assign range_ok = time_in_range(stg_q);
`else
  assign range_ok = 1'b1;
`endif

  always_comb begin
    pos_d  = pos_q;
    stg_d  = stg_q;
    out_d  = out_q;
    tv_d   = 1'b0;
    err_d  = 1'b0;
    code_d = code_q;
    if (char_valid) begin
      case (pos_q)
        POS_H_T, POS_H_O, POS_M_T, POS_M_O, POS_S_T, POS_S_O: begin
          if (is_digit) begin
            stg_d[digit_idx(pos_q)] = digit_val;
            pos_d = pos_q + 4'd1;
          end else if (!((pos_q == POS_H_T) && (char_data == TERM_CHAR))) begin
            // Terminator at idle is a blank line or CR/LF tail, not an error.
            err_d  = 1'b1;
            code_d = ERR_FORMAT;
            pos_d  = POS_H_T;
          end
        end
        POS_SEP1, POS_SEP2: begin
          if (char_data == SEP_CHAR) begin
            pos_d = pos_q + 4'd1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_FORMAT;
            pos_d  = POS_H_T;
          end
        end
        POS_TERM: begin
          pos_d = POS_H_T;
          if (char_data != TERM_CHAR) begin
            err_d  = 1'b1;
            code_d = ERR_FORMAT;
          end else if (range_ok) begin
            out_d = stg_q;
            tv_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_RANGE;
          end
        end
        default: pos_d = POS_H_T;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= POS_H_T;
      stg_q  <= '0;
      out_q  <= '0;
      tv_q   <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      pos_q  <= pos_d;
      stg_q  <= stg_d;
      out_q  <= out_d;
      tv_q   <= tv_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign hour_t     = out_q[5];
  assign hour_o     = out_q[4];
  assign min_t      = out_q[3];
  assign min_o      = out_q[2];
  assign sec_t      = out_q[1];
  assign sec_o      = out_q[0];
  assign time_valid = tv_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign busy       = (pos_q != POS_H_T);

endmodule

// File: tb/tb_char_to_time_parser.sv
// Scoreboard bench for char_to_time_parser: expected strobes are queued as bytes are driven.
module tb_char_to_time_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_data;
  logic [3:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
  logic       time_valid, err, busy;
  logic [1:0] err_code;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [23:0] digits;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_ev;
  int          checks   = 0;
  int          failures = 0;
  int          err_seen = 0;
  int          err_base;
  logic [23:0] pub;
  logic [23:0] digits;

  always #5 clk = ~clk;

  assign digits = {hour_t, hour_o, min_t, min_o, sec_t, sec_o};

  char_to_time_parser dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .hour_t     (hour_t),
    .hour_o     (hour_o),
    .min_t      (min_t),
    .min_o      (min_o),
    .sec_t      (sec_t),
    .sec_o      (sec_o),
    .time_valid (time_valid),
    .err        (err),
    .err_code   (err_code),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      char_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic exp_ok(input logic [23:0] d);
    ev_t e;
    e.is_err = 1'b0;
    e.code   = 2'b00;
    e.digits = d;
    sb.push_back(e);
    pub = d;
  endtask

  task automatic exp_err(input logic [1:0] c);
    ev_t e;
    e.is_err = 1'b1;
    e.code   = c;
    e.digits = pub;
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (time_valid || err) begin
      chk("strobe_excl", {31'b0, time_valid & err}, 32'd0);
      if (err) err_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_ev = sb.pop_front();
        chk("strobe_kind", {31'b0, err}, {31'b0, mon_ev.is_err});
        if (mon_ev.is_err) chk("err_code", {30'b0, err_code}, {30'b0, mon_ev.code});
        chk("digits", {8'b0, digits}, {8'b0, mon_ev.digits});
      end
    end
  end

  initial begin
    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    pub        = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_digits", {8'b0, digits}, 32'h0);
    chk("rst_tv", {31'b0, time_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_code", {30'b0, err_code}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Basic frame, back-to-back bytes
    put(8'h31);
    after_edge();
    chk("busy_rise", {31'b0, busy}, 32'd1);
    send_str("2:34:56");
    exp_ok(24'h123456);
    put(8'h0D);
    after_edge();
    chk("busy_fall", {31'b0, busy}, 32'd0);
    idle(2);
    chk("err_none_t1", err_seen, 0);

    // Max legal time, then out-of-range hour
    send_str("23:59:59");
    exp_ok(24'h235959);
    put(8'h0D);
    send_str("24:00:00");
`ifdef PARSER_RANGE_CHECK_EN
    exp_err(2'b10);
`else
    exp_ok(24'h240000);
`endif
    put(8'h0D);
    idle(2);

    // Bad separator, then the tail resynchronises wrongly
    err_base = err_seen;
    send_str("12");
    exp_err(2'b01);
    put(8'h2D);
    after_edge();
    chk("busy_after_dash", {31'b0, busy}, 32'd0);
    send_str("34:56");
    exp_err(2'b01);
    put(8'h0D);
    idle(3);
    chk("err_cnt_t3", err_seen - err_base, 2);
    chk("code_hold", {30'b0, err_code}, 32'd1);

    // CR ignored at idle, LF is a format error, then a valid frame
    err_base = err_seen;
    put(8'h0D);
    after_edge();
    chk("cr_ignored_busy", {31'b0, busy}, 32'd0);
    exp_err(2'b01);
    put(8'h0A);
    send_str("01:02:03");
    exp_ok(24'h010203);
    put(8'h0D);
    idle(3);
    chk("err_cnt_t4", err_seen - err_base, 1);

    // Partial frame with gaps, aborted by reset
    put(8'h31); idle(1);
    put(8'h32); idle(2);
    put(8'h3A); idle(1);
    put(8'h33);
    after_edge();
    chk("busy_partial", {31'b0, busy}, 32'd1);
    @(negedge clk);
    char_valid = 1'b0;
    #2 rst = 1'b1;
    #6 rst = 1'b0;
    #1;
    chk("rst2_busy", {31'b0, busy}, 32'd0);
    chk("rst2_digits", {8'b0, digits}, 32'h0);
    pub = 24'h0;
    send_str("00:00:01");
    exp_ok(24'h000001);
    put(8'h0D);
    idle(4);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
